// File: rtl/user_pkg.sv
// Shared types and constants for the user-domain IO bridge.
package user_pkg;

    localparam int unsigned AidWidth = 4;

    // OBI subordinate request, flattened A channel.
    typedef struct packed {
        logic                req;
        logic                we;
        logic [3:0]          be;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic [AidWidth-1:0] aid;
    } sbr_obi_req_t;

    // OBI subordinate response, flattened R channel.
    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        logic [31:0]         rdata;
        logic                err;
        logic [AidWidth-1:0] rid;
    } sbr_obi_rsp_t;

    // Register byte offsets; decode only looks at bits [5:2].
    localparam logic [7:0] UserIoCtrlOffset    = 8'h00;
    localparam logic [7:0] UserIoStatusOffset  = 8'h04;
    localparam logic [7:0] UserIoTimeoutOffset = 8'h08;
    localparam logic [7:0] UserIoInOffset      = 8'h10;
    localparam logic [7:0] UserIoOutOffset     = 8'h20;

    localparam int unsigned CtrlStartBit     = 0;
    localparam int unsigned CtrlIrqEnBit     = 1;
    localparam int unsigned StatusBusyBit    = 0;
    localparam int unsigned StatusDoneBit    = 1;
    localparam int unsigned StatusTimeoutBit = 2;
    localparam int unsigned StatusOverrunBit = 3;

    localparam logic [31:0] UserIoErrRdata = 32'hBADCAB1E;

    typedef enum logic [1:0] {IoIdle, IoStartP, IoWait} user_io_state_e;

endpackage

// File: rtl/user_io_seq.sv
// Operation sequencer: start pulse, wait for done or timeout, done wins ties.
module user_io_seq
    import user_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        core_done_i,
    input  logic [31:0] timeout_i,
    output logic        core_start_o,
    output logic        busy_o,
    output logic        done_set_o,
    output logic        timeout_set_o
);

    user_io_state_e state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           expired;

    // A zero timeout disables expiry entirely.
    assign expired = (timeout_i != 32'd0) && (cnt_q == timeout_i - 32'd1);
    assign busy_o  = (state_q != IoIdle);

    // Next-state, counter and completion strobes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_start_o  = 1'b0;
        done_set_o    = 1'b0;
        timeout_set_o = 1'b0;
        case (state_q)
            IoIdle: begin
                if (start_i) begin
                    state_d = IoStartP;
                end
            end
            IoStartP: begin
                core_start_o = 1'b1;
                cnt_d        = 32'd0;
                state_d      = IoWait;
            end
            IoWait: begin
                if (core_done_i) begin
                    done_set_o = 1'b1;
                    state_d    = IoIdle;
                end else if (expired) begin
                    timeout_set_o = 1'b1;
                    state_d       = IoIdle;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IoIdle;
        endcase
    end

    // State and cycle counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IoIdle;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/user_obi_io_bridge.sv
// OBI register file bridging software to a fixed-function user core.
module user_obi_io_bridge
    import user_pkg::*;
#(
    parameter int unsigned IN_BYTES   = 7,
    parameter int unsigned OUT_BYTES  = 6,
    parameter logic [31:0] TimeoutRst = 32'd1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   testmode_i,
    input  sbr_obi_req_t           obi_req_i,
    output sbr_obi_rsp_t           obi_rsp_o,
    output logic [8*IN_BYTES-1:0]  core_data_o,
    output logic                   core_start_o,
    input  logic [8*OUT_BYTES-1:0] core_data_i,
    input  logic                   core_done_i,
    output logic                   irq_o
);

    if (IN_BYTES < 1 || IN_BYTES > 8) begin : gen_in_bytes_chk
        $error("IN_BYTES must be in 1..8");
    end
    if (OUT_BYTES < 1 || OUT_BYTES > 8) begin : gen_out_bytes_chk
        $error("OUT_BYTES must be in 1..8");
    end

    localparam logic [3:0] CtrlIdx   = UserIoCtrlOffset[5:2];
    localparam logic [3:0] StatusIdx = UserIoStatusOffset[5:2];
    localparam logic [3:0] TmoIdx    = UserIoTimeoutOffset[5:2];
    localparam logic [3:0] InIdx     = UserIoInOffset[5:2];
    localparam logic [3:0] OutIdx    = UserIoOutOffset[5:2];

    logic [63:0] in_q, in_d, out_q, out_d;
    logic [31:0] tmo_q, tmo_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d, to_q, to_d, ovr_q, ovr_d;
    logic        irq_q;
    logic        rvalid_q, err_q;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic [AidWidth-1:0] rid_q;

    logic [3:0]  idx;
    logic        is_ctrl, is_status, is_tmo, is_in, is_out;
    logic        req_err, wr_en, start_wr, busy, done_set, to_set;
    logic [3:0]  w1c;
    logic        unused_sigs;

    assign idx         = obi_req_i.addr[5:2];
    assign unused_sigs = ^{testmode_i, obi_req_i.addr[31:6], obi_req_i.addr[1:0]};

    // Address decode; IN writes are refused while an operation is running.
    always_comb begin
        is_ctrl   = (idx == CtrlIdx);
        is_status = (idx == StatusIdx);
        is_tmo    = (idx == TmoIdx);
        is_in     = (idx == InIdx) || (idx == InIdx + 4'd1);
        is_out    = (idx == OutIdx) || (idx == OutIdx + 4'd1);
        req_err   = ~(is_ctrl | is_status | is_tmo | is_in | is_out)
                  | (obi_req_i.we & is_out)
                  | (obi_req_i.we & is_in & busy);
    end

    assign wr_en    = obi_req_i.req & obi_req_i.we & ~req_err;
    assign start_wr = wr_en & is_ctrl & obi_req_i.be[0] & obi_req_i.wdata[CtrlStartBit];

    user_io_seq u_seq (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_wr & ~busy),
        .core_done_i   (core_done_i),
        .timeout_i     (tmo_q),
        .core_start_o  (core_start_o),
        .busy_o        (busy),
        .done_set_o    (done_set),
        .timeout_set_o (to_set)
    );

    // Register next-state; hardware sets take priority over software clears.
    always_comb begin
        in_d     = in_q;
        out_d    = out_q;
        tmo_d    = tmo_q;
        irq_en_d = irq_en_q;
        w1c      = 4'b0;
        if (wr_en && is_status && obi_req_i.be[0]) begin
            w1c = obi_req_i.wdata[3:0];
        end
        done_d = done_set | (done_q & ~w1c[StatusDoneBit]);
        to_d   = to_set | (to_q & ~w1c[StatusTimeoutBit]);
        ovr_d  = (start_wr & busy) | (ovr_q & ~w1c[StatusOverrunBit]);
        if (wr_en && is_ctrl && obi_req_i.be[0]) begin
            irq_en_d = obi_req_i.wdata[CtrlIrqEnBit];
        end
        if (wr_en && is_tmo) begin
            for (int j = 0; j < 4; j++) begin
                if (obi_req_i.be[j]) tmo_d[8*j +: 8] = obi_req_i.wdata[8*j +: 8];
            end
        end
        if (wr_en && is_in) begin
            for (int w = 0; w < 2; w++) begin
                for (int j = 0; j < 4; j++) begin
                    if (idx[0] == w[0] && obi_req_i.be[j] && (4*w + j) < IN_BYTES) begin
                        in_d[8*(4*w + j) +: 8] = obi_req_i.wdata[8*j +: 8];
                    end
                end
            end
        end
        if (done_set) begin
            out_d = 64'(core_data_i);
        end
    end

    // Read data mux for the current request.
    always_comb begin
        rd_val = 32'd0;
        if (is_ctrl) begin
            rd_val[CtrlIrqEnBit] = irq_en_q;
        end else if (is_status) begin
            rd_val[StatusBusyBit]    = busy;
            rd_val[StatusDoneBit]    = done_q;
            rd_val[StatusTimeoutBit] = to_q;
            rd_val[StatusOverrunBit] = ovr_q;
        end else if (is_tmo) begin
            rd_val = tmo_q;
        end else if (is_in) begin
            rd_val = idx[0] ? in_q[63:32] : in_q[31:0];
        end else if (is_out) begin
            rd_val = idx[0] ? out_q[63:32] : out_q[31:0];
        end
        rdata_d = req_err ? UserIoErrRdata : (obi_req_i.we ? 32'd0 : rd_val);
    end

    // Register file, interrupt and response pipeline state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_q     <= 64'd0;
            out_q    <= 64'd0;
            tmo_q    <= TimeoutRst;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rid_q    <= '0;
        end else begin
            in_q     <= in_d;
            out_q    <= out_d;
            tmo_q    <= tmo_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            to_q     <= to_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_en_q & (done_q | to_q);
            rvalid_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                err_q   <= req_err;
                rdata_q <= rdata_d;
                rid_q   <= obi_req_i.aid;
            end
        end
    end

    // Response drive; grant is immediate since there is no back-pressure.
    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = obi_req_i.req;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rdata  = rdata_q;
        obi_rsp_o.err    = err_q;
        obi_rsp_o.rid    = rid_q;
    end

    assign core_data_o = in_q[8*IN_BYTES-1:0];
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_user_obi_io_bridge.sv
// Scoreboard bench: register-level reference model, decoupled response monitor.
module tb_user_obi_io_bridge;
    import user_pkg::*;

    localparam int unsigned InBytes  = 7;
    localparam int unsigned OutBytes = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic testmode = 1'b0;
    sbr_obi_req_t req;
    sbr_obi_rsp_t rsp;
    logic [8*InBytes-1:0]  core_data_out;
    logic                  core_start;
    logic [8*OutBytes-1:0] core_data_in;
    logic                  core_done;
    logic                  irq;

    user_obi_io_bridge #(
        .IN_BYTES   (InBytes),
        .OUT_BYTES  (OutBytes),
        .TimeoutRst (32'd1024)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .testmode_i   (testmode),
        .obi_req_i    (req),
        .obi_rsp_o    (rsp),
        .core_data_o  (core_data_out),
        .core_start_o (core_start),
        .core_data_i  (core_data_in),
        .core_done_i  (core_done),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  rid;
        int          x;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [63:0] m_in, m_out;
    logic [31:0] m_tmo;
    logic        m_irq_en, m_done, m_to, m_ovr;
    bit          m_op_active;
    bit          m_op_is_done;
    int          m_op_end;
    logic [47:0] m_op_data;
    int          m_starts = 0;
    int          n_start_seen = 0;
    int          plan_delay = 0;
    logic [47:0] plan_data = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in = '0; m_out = '0; m_tmo = 32'd1024;
        m_irq_en = 0; m_done = 0; m_to = 0; m_ovr = 0;
        m_op_active = 0;
    endtask

    // Completion becomes visible to requests sampled after the finishing edge.
    task automatic apply_pending(input int x);
        if (m_op_active && x > m_op_end) begin
            m_op_active = 0;
            if (m_op_is_done) begin
                m_done = 1;
                m_out  = 64'(m_op_data);
            end else begin
                m_to = 1;
            end
        end
    endtask

    // Operation accepted at edge x: one start cycle, then m wait cycles.
    task automatic launch(input int x);
        int m;
        m_starts++;
        if (plan_delay > 0 && (m_tmo == 0 || plan_delay <= int'(m_tmo))) begin
            m_op_is_done = 1;
            m = plan_delay;
        end else begin
            m_op_is_done = 0;
            m = int'(m_tmo);
        end
        m_op_end    = x + 1 + m;
        m_op_data   = plan_data;
        m_op_active = 1;
    endtask

    function automatic logic [31:0] model_read(input int idx, input bit busy);
        case (idx)
            0: return {30'd0, m_irq_en, 1'b0};
            1: return {28'd0, m_ovr, m_to, m_done, busy};
            2: return m_tmo;
            4: return m_in[31:0];
            5: return m_in[63:32];
            8: return m_out[31:0];
            9: return m_out[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input int x, input int idx, input logic [3:0] be,
                               input logic [31:0] wd, input bit busy);
        case (idx)
            0: if (be[0]) begin
                m_irq_en = wd[1];
                if (wd[0]) begin
                    if (busy) m_ovr = 1;
                    else launch(x);
                end
            end
            1: if (be[0]) begin
                if (wd[1]) m_done = 0;
                if (wd[2]) m_to = 0;
                if (wd[3]) m_ovr = 0;
            end
            2: for (int j = 0; j < 4; j++) if (be[j]) m_tmo[8*j +: 8] = wd[8*j +: 8];
            4, 5: for (int j = 0; j < 4; j++) begin
                int b;
                b = 4 * (idx - 4) + j;
                if (be[j] && b < int'(InBytes)) m_in[8*b +: 8] = wd[8*j +: 8];
            end
            default: ;
        endcase
    endtask

    // Drive one request for one cycle and push its predicted response.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        exp_t e;
        int x, idx;
        bit busy, mapped, err;
        logic [3:0] aid;
        x   = cyc + 1;
        idx = int'(addr[5:2]);
        aid = 4'($urandom_range(0, 15));
        apply_pending(x);
        busy   = m_op_active;
        mapped = idx inside {0, 1, 2, 4, 5, 8, 9};
        err    = !mapped || (we && idx inside {8, 9}) || (we && idx inside {4, 5} && busy);
        e.rid = aid; e.err = err; e.x = x;
        if (err) e.rdata = 32'hBADCAB1E;
        else if (we) begin
            e.rdata = 32'd0;
            model_write(x, idx, be, wd, busy);
        end else e.rdata = model_read(idx, busy);
        exp_q.push_back(e);
        req.req = 1'b1; req.we = we; req.be = be; req.addr = addr;
        req.wdata = wd; req.aid = aid;
        @(posedge clk); #1;
        req.req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        issue(1'b1, addr, be, wd);
    endtask

    task automatic rd(input logic [31:0] addr);
        issue(1'b0, addr, 4'hF, 32'($urandom));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_op();
        int guard = 0;
        while (m_op_active && cyc <= m_op_end + 1 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        idle(2);
    endtask

    task automatic check_irq(input string nm);
        idle(3);
        apply_pending(cyc);
        check(nm, irq, m_irq_en & (m_done | m_to));
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt", rsp.gnt, req.req);
            if (rsp.rvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rdata", rsp.rdata, e.rdata);
                    check("err", rsp.err, e.err);
                    check("rid", rsp.rid, e.rid);
                    check("rvalid_cycle", 64'(cyc), 64'(e.x));
                end
            end
        end
    end

    // Core responder: returns plan_data after plan_delay wait cycles (0 = never).
    initial begin
        core_done = 1'b0;
        core_data_in = '0;
        forever begin
            @(negedge clk);
            if (rst_n && core_start) begin
                int d;
                d = plan_delay;
                n_start_seen++;
                check("core_data_o", core_data_out, m_in[8*InBytes-1:0]);
                @(negedge clk);
                check("start_width", core_start, 1'b0);
                if (d > 0) begin
                    if (d > 1) begin
                        repeat (d - 1) @(posedge clk);
                        #1;
                    end
                    core_data_in = plan_data;
                    core_done = 1'b1;
                    @(posedge clk); #1;
                    core_done = 1'b0;
                    core_data_in = 48'($urandom);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", rsp.rvalid, 1'b0);
        check("rst_start", core_start, 1'b0);
        check("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Reset values of every register, upper address bits ignored.
        rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h10); rd(32'h14); rd(32'h20); rd(32'h24);
        rd(32'hABCD_0008);
        idle(2);
        check("idle_irq", irq, 1'b0);

        // Basic operation with done after 5 cycles.
        wr(32'h10, 4'hF, 32'h44332211);
        wr(32'h14, 4'b0111, 32'h88776655);
        wr(32'h00, 4'h1, 32'h2);
        plan_delay = 5; plan_data = 48'hCAFEBABE1234;
        wr(32'h00, 4'h1, 32'h3);
        wait_op();
        check("core_data_const", core_data_out, 56'h77665544332211);
        rd(32'h20); rd(32'h24); rd(32'h04); rd(32'h14);
        check("start_count", n_start_seen, m_starts);
        check_irq("irq_done");
        wr(32'h04, 4'h1, 32'h2);
        check_irq("irq_cleared");

        // Done outside WAIT is ignored.
        core_data_in = 48'h111111111111; core_done = 1'b1;
        idle(1);
        core_done = 1'b0;
        rd(32'h20); rd(32'h04);

        // Timeout, overrun and blocked IN writes during WAIT.
        wr(32'h08, 4'hF, 32'd8);
        plan_delay = 0;
        wr(32'h00, 4'h1, 32'h3);
        idle(1);
        wr(32'h00, 4'h1, 32'h3);
        wr(32'h10, 4'hF, 32'hDEADBEEF);
        rd(32'h10); rd(32'h04);
        wait_op();
        rd(32'h04); rd(32'h20); rd(32'h24);
        check("start_count_to", n_start_seen, m_starts);
        check_irq("irq_timeout");
        wr(32'h04, 4'h1, 32'hE);
        check_irq("irq_to_cleared");

        // Done and expiry in the same cycle.
        wr(32'h08, 4'hF, 32'd3);
        plan_delay = 3; plan_data = 48'h0123456789AB;
        wr(32'h00, 4'h1, 32'h1);
        wait_op();
        rd(32'h04); rd(32'h20); rd(32'h24);
        check_irq("irq_disabled");
        wr(32'h04, 4'h1, 32'hE);

        // Errors and back-to-back traffic.
        rd(32'h30);
        wr(32'h20, 4'hF, 32'h12345678);
        rd(32'h20); rd(32'h0C); rd(32'h3C); rd(32'h08); rd(32'h00);

        // Randomised operations.
        for (int it = 0; it < 20; it++) begin
            int d, t;
            t = $urandom_range(1, 12);
            d = $urandom_range(0, 12);
            plan_delay = d;
            plan_data  = {16'($urandom), 32'($urandom)};
            wr(32'h08, 4'hF, 32'(t));
            wr(32'h10, 4'($urandom), 32'($urandom));
            wr(32'h14, 4'($urandom), 32'($urandom));
            wr(32'h00, 4'h1 | 4'($urandom), {30'd0, 1'($urandom), 1'b1});
            for (int k = 0; k < 4; k++) begin
                issue(1'($urandom), {26'($urandom), 4'($urandom), 2'($urandom)},
                      4'($urandom), 32'($urandom) & 32'hFFFF_FFFE);
            end
            wait_op();
            rd(32'h04); rd(32'h20); rd(32'h24);
            check("start_count_rand", n_start_seen, m_starts);
            check_irq("irq_rand");
            wr(32'h04, 4'h1, 32'($urandom));
        end
        wr(32'h04, 4'h1, 32'hE);

        // Reset in the middle of an operation.
        wr(32'h08, 4'hF, 32'd20);
        plan_delay = 6; plan_data = 48'hFEEDFACE0001;
        wr(32'h00, 4'h1, 32'h3);
        idle(3);
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        idle(2);
        check("rst_mid_irq", irq, 1'b0);
        rst_n = 1'b1;
        idle(10);
        rd(32'h04); rd(32'h20); rd(32'h10); rd(32'h08); rd(32'h00);
        check("start_count_rst", n_start_seen, m_starts);
        check_irq("irq_after_rst");

        idle(3);
        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
